// File: rtl/reg_op_pkg.sv
// Shared constants for the register-file sequencer: widths, opcodes,
// FSM state encoding and rf_valid bit positions.
package reg_op_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_ADDI = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_LI   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // rf_valid bit positions
  localparam int RF_WR_BIT  = 2;
  localparam int RF_RD1_BIT = 1;
  localparam int RF_RD2_BIT = 0;

endpackage

// File: rtl/reg_op_alu.sv
// Combinational 8-bit ALU for the sequencer.
// Macro ALU_SHIFT_EN: when defined, opcode 110 is SHL; otherwise it is a
// NOP (wr_o=0) and no shifter is built.
module reg_op_alu
  import reg_op_pkg::*;
(
  input  logic [2:0]        opcode_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] value_o,
  output logic              carry_o,
  output logic              wr_o
);

  logic [DATA_W:0] add_ab;
  logic [DATA_W:0] add_ai;
  logic [DATA_W:0] sub_ab;

  // Nine-bit sums expose carry-out; the subtraction MSB is the borrow (A<B).
  assign add_ab = {1'b0, a_i} + {1'b0, b_i};
  assign add_ai = {1'b0, a_i} + {1'b0, imm_i};
  assign sub_ab = {1'b0, a_i} - {1'b0, b_i};

  // Operation select; wr_o=0 marks a result that must not be committed.
  always_comb begin
    value_o = '0;
    carry_o = 1'b0;
    wr_o    = 1'b1;
    case (opcode_i)
      OP_ADD:  begin value_o = add_ab[DATA_W-1:0]; carry_o = add_ab[DATA_W]; end
      OP_SUB:  begin value_o = sub_ab[DATA_W-1:0]; carry_o = sub_ab[DATA_W]; end
      OP_AND:  value_o = a_i & b_i;
      OP_OR:   value_o = a_i | b_i;
      OP_XOR:  value_o = a_i ^ b_i;
      OP_ADDI: begin value_o = add_ai[DATA_W-1:0]; carry_o = add_ai[DATA_W]; end
`ifdef ALU_SHIFT_EN
      OP_SHL:  value_o = a_i << b_i[2:0];
`else
      OP_SHL:  wr_o = 1'b0;
`endif
      OP_LI:   value_o = imm_i;
      default: wr_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/reg_op_sequencer.sv
// Four-cycle single-issue sequencer in front of the 32x8 register file:
// IDLE -> READ -> EXEC -> WB. Honours ALU_SHIFT_EN through reg_op_alu.
module reg_op_sequencer
  import reg_op_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] imm,
  output logic [2:0]        rf_valid,
  output logic [ADDR_W-1:0] rf_read_addr_1,
  output logic [ADDR_W-1:0] rf_read_addr_2,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [DATA_W-1:0] rf_read_1,
  input  logic [DATA_W-1:0] rf_read_2,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              done
);

  state_e            state_q, state_d;
  logic              ready_q;
  logic              accept;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rs1_q, rs2_q, rd_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] result_q;
  logic              carry_q;
  logic              wb_en_q;
  logic [DATA_W-1:0] alu_value;
  logic              alu_carry;
  logic              alu_wr;

  // ready is registered so it stays low throughout reset and rises one
  // edge after release; it can only be high while the FSM is in IDLE.
  assign accept      = instr_valid & ready_q;
  assign instr_ready = ready_q;
  assign result      = result_q;
  assign carry       = carry_q;

  reg_op_alu u_alu (
    .opcode_i (op_q),
    .a_i      (rf_read_1),
    .b_i      (rf_read_2),
    .imm_i    (imm_q),
    .value_o  (alu_value),
    .carry_o  (alu_carry),
    .wr_o     (alu_wr)
  );

  // State register and ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE);
    end
  end

  // Capture the instruction fields on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q  <= '0;
      imm_q <= '0;
    end else if (accept) begin
      op_q  <= opcode;
      rs1_q <= rs1;
      rs2_q <= rs2;
      rd_q  <= rd;
      imm_q <= imm;
    end
  end

  // Register the ALU outcome at the end of EXEC; a NOP leaves result/carry alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      wb_en_q  <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      wb_en_q <= alu_wr;
      if (alu_wr) begin
        result_q <= alu_value;
        carry_q  <= alu_carry;
      end
    end
  end

  // Next-state and register-file handshake decode; addresses/data are zero
  // whenever their rf_valid bit is low.
  always_comb begin
    state_d        = state_q;
    rf_valid       = 3'b000;
    rf_read_addr_1 = '0;
    rf_read_addr_2 = '0;
    rf_write_addr  = '0;
    rf_write_data  = '0;
    done           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_READ;
      end
      ST_READ: begin
        state_d                = ST_EXEC;
        rf_valid[RF_RD1_BIT]   = 1'b1;
        rf_valid[RF_RD2_BIT]   = 1'b1;
        rf_read_addr_1         = rs1_q;
        rf_read_addr_2         = rs2_q;
      end
      ST_EXEC: begin
        state_d = ST_WB;
      end
      ST_WB: begin
        state_d = ST_IDLE;
        done    = 1'b1;
        if (wb_en_q) begin
          rf_valid[RF_WR_BIT] = 1'b1;
          rf_write_addr       = rd_q;
          rf_write_data       = result_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Testbench for reg_op_sequencer: register-file model, table of directed
// vectors, hand-written reset/back-to-back sequences and random instructions
// checked against an arithmetic reference model.
module tb_reg_op_sequencer;
  import reg_op_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        opcode;
  logic [ADDR_W-1:0] rs1, rs2, rd;
  logic [DATA_W-1:0] imm;
  logic [2:0]        rf_valid;
  logic [ADDR_W-1:0] rf_read_addr_1, rf_read_addr_2, rf_write_addr;
  logic [DATA_W-1:0] rf_write_data;
  logic [DATA_W-1:0] rf_read_1, rf_read_2;
  logic [DATA_W-1:0] result;
  logic              carry;
  logic              done;

  reg_op_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .opcode         (opcode),
    .rs1            (rs1),
    .rs2            (rs2),
    .rd             (rd),
    .imm            (imm),
    .rf_valid       (rf_valid),
    .rf_read_addr_1 (rf_read_addr_1),
    .rf_read_addr_2 (rf_read_addr_2),
    .rf_write_addr  (rf_write_addr),
    .rf_write_data  (rf_write_data),
    .rf_read_1      (rf_read_1),
    .rf_read_2      (rf_read_2),
    .result         (result),
    .carry          (carry),
    .done           (done)
  );

  int nchecks = 0;
  int nerr    = 0;

  // Register file environment (no reset; cleared once at start) plus event counters.
  logic [7:0] rf_mem [32];
  logic       clr_mem;
  int         done_cnt = 0;
  int         wr_cnt   = 0;

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 8'h00;
    end else if (rf_valid[2]) begin
      rf_mem[rf_write_addr] <= rf_write_data;
    end
    if (rf_valid[1]) rf_read_1 <= rf_mem[rf_read_addr_1];
    if (rf_valid[0]) rf_read_2 <= rf_mem[rf_read_addr_2];
    if (done)        done_cnt  <= done_cnt + 1;
    if (rf_valid[2]) wr_cnt    <= wr_cnt + 1;
  end

  // Reference state
  logic [7:0] ref_rf [32];
  int         ref_result;
  int         ref_carry;
  int         n_instr  = 0;
  int         n_writes = 0;

  typedef struct {
    logic [2:0] op;
    logic [4:0] s1;
    logic [4:0] s2;
    logic [4:0] d;
    logic [7:0] im;
    int         exp_res;
    int         exp_c;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Operation semantics in plain integer arithmetic.
  function automatic void alu_model(input logic [2:0] op, input int a, input int b,
                                    input int im, output int val, output int c,
                                    output int wr);
    val = 0; c = 0; wr = 1;
    case (op)
      3'd0: begin val = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
      3'd1: begin val = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      3'd2: val = a & b;
      3'd3: val = a | b;
      3'd4: val = a ^ b;
      3'd5: begin val = (a + im) % 256; c = (a + im > 255) ? 1 : 0; end
`ifdef ALU_SHIFT_EN
      3'd6: val = (a * (1 << (b % 8))) % 256;
`else
      3'd6: wr = 0;
`endif
      default: val = im;
    endcase
  endfunction

  // Issue one instruction and check every cycle of its occupancy.
  task automatic run_instr(input logic [2:0] t_op, input logic [4:0] t_rs1,
                           input logic [4:0] t_rs2, input logic [4:0] t_rd,
                           input logic [7:0] t_imm, input bit hold);
    int waitn, val, c, wr;
    @(negedge clk);
    instr_valid = 1'b1;
    opcode = t_op; rs1 = t_rs1; rs2 = t_rs2; rd = t_rd; imm = t_imm;
    waitn = 0;
    while (!instr_ready && waitn < 12) begin
      @(negedge clk);
      waitn++;
    end
    chk("ready_wait_cycles", waitn, 0);
    chk("ready_at_accept", int'(instr_ready), 1);
    alu_model(t_op, int'(ref_rf[t_rs1]), int'(ref_rf[t_rs2]), int'(t_imm), val, c, wr);
    @(posedge clk); #1;
    if (!hold) instr_valid = 1'b0;
    // READ
    @(negedge clk);
    chk("read_rf_valid", int'(rf_valid), 3);
    chk("read_addr1", int'(rf_read_addr_1), int'(t_rs1));
    chk("read_addr2", int'(rf_read_addr_2), int'(t_rs2));
    chk("read_waddr", int'(rf_write_addr), 0);
    chk("read_ready", int'(instr_ready), 0);
    chk("read_done", int'(done), 0);
    // EXEC
    @(negedge clk);
    chk("exec_rf_valid", int'(rf_valid), 0);
    chk("exec_addr1", int'(rf_read_addr_1), 0);
    chk("exec_ready", int'(instr_ready), 0);
    chk("exec_done", int'(done), 0);
    // WB
    @(negedge clk);
    if (wr != 0) begin
      ref_result = val;
      ref_carry  = c;
      n_writes++;
    end
    chk("wb_done", int'(done), 1);
    chk("wb_ready", int'(instr_ready), 0);
    chk("wb_rf_valid", int'(rf_valid), (wr != 0) ? 4 : 0);
    chk("wb_waddr", int'(rf_write_addr), (wr != 0) ? int'(t_rd) : 0);
    chk("wb_wdata", int'(rf_write_data), (wr != 0) ? val : 0);
    chk("wb_raddr1", int'(rf_read_addr_1), 0);
    chk("wb_result", int'(result), ref_result);
    chk("wb_carry", int'(carry), ref_carry);
    @(posedge clk); #1;
    if (wr != 0) ref_rf[t_rd] = 8'(val);
    chk("rf_dest", int'(rf_mem[t_rd]), int'(ref_rf[t_rd]));
    n_instr++;
    $display("instr %0d: op=%0d rs1=%0d rs2=%0d rd=%0d imm=%02h -> result=%02h carry=%0d wr=%0d",
             n_instr, t_op, t_rs1, t_rs2, t_rd, t_imm, result, carry, wr);
  endtask

  initial begin
    int wr_before;

    vecs[0]  = '{OP_LI,   5'd0,  5'd0,  5'd3,  8'hA5, 'hA5, 0};
    vecs[1]  = '{OP_ADD,  5'd3,  5'd3,  5'd4,  8'h00, 'h4A, 1};
    vecs[2]  = '{OP_LI,   5'd0,  5'd0,  5'd7,  8'h05, 'h05, 0};
    vecs[3]  = '{OP_LI,   5'd0,  5'd0,  5'd8,  8'h07, 'h07, 0};
    vecs[4]  = '{OP_SUB,  5'd7,  5'd8,  5'd9,  8'h00, 'hFE, 1};
    vecs[5]  = '{OP_SUB,  5'd8,  5'd7,  5'd10, 8'h00, 'h02, 0};
    vecs[6]  = '{OP_LI,   5'd0,  5'd0,  5'd2,  8'h81, 'h81, 0};
    vecs[7]  = '{OP_LI,   5'd0,  5'd0,  5'd5,  8'h03, 'h03, 0};
`ifdef ALU_SHIFT_EN
    vecs[8]  = '{OP_SHL,  5'd2,  5'd5,  5'd2,  8'h00, 'h08, 0};
`else
    vecs[8]  = '{OP_SHL,  5'd2,  5'd5,  5'd2,  8'h00, 'h03, 0};
`endif
    vecs[9]  = '{OP_AND,  5'd3,  5'd4,  5'd11, 8'h00, 'h00, 0};
    vecs[10] = '{OP_OR,   5'd3,  5'd4,  5'd12, 8'h00, 'hEF, 0};
    vecs[11] = '{OP_XOR,  5'd3,  5'd9,  5'd13, 8'h00, 'h5B, 0};
    vecs[12] = '{OP_ADDI, 5'd4,  5'd0,  5'd14, 8'hFF, 'h49, 1};
    vecs[13] = '{OP_LI,   5'd0,  5'd0,  5'd0,  8'h5A, 'h5A, 0};
    vecs[14] = '{OP_ADD,  5'd0,  5'd0,  5'd15, 8'h00, 'hB4, 0};
    vecs[15] = '{OP_LI,   5'd0,  5'd0,  5'd6,  8'h33, 'h33, 0};

    for (int i = 0; i < 32; i++) ref_rf[i] = 8'h00;
    ref_result = 0;
    ref_carry  = 0;
    rst_n = 1'b0; clr_mem = 1'b1; instr_valid = 1'b0;
    opcode = '0; rs1 = '0; rs2 = '0; rd = '0; imm = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(instr_ready), 0);
    chk("rst_rf_valid", int'(rf_valid), 0);
    chk("rst_addr1", int'(rf_read_addr_1), 0);
    chk("rst_addr2", int'(rf_read_addr_2), 0);
    chk("rst_waddr", int'(rf_write_addr), 0);
    chk("rst_wdata", int'(rf_write_data), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_carry", int'(carry), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1; clr_mem = 1'b0;
    @(negedge clk);
    chk("ready_after_release", int'(instr_ready), 1);
    $display("reset released: instr_ready=%0d", instr_ready);

    // Directed table
    for (int i = 0; i < 16; i++) begin
      run_instr(vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].d, vecs[i].im, 1'b0);
      chk("tbl_result", int'(result), vecs[i].exp_res);
      chk("tbl_carry", int'(carry), vecs[i].exp_c);
    end
    chk("shl_dest_r2", int'(rf_mem[2]),
`ifdef ALU_SHIFT_EN
        'h08
`else
        'h81
`endif
    );

    // Reset asserted during EXEC of ADD r6 <- r3 + r4
    @(negedge clk);
    instr_valid = 1'b1; opcode = OP_ADD; rs1 = 5'd3; rs2 = 5'd4; rd = 5'd6; imm = 8'h00;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);           // READ
    @(negedge clk);           // EXEC
    wr_before = wr_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", int'(instr_ready), 0);
    chk("abort_rf_valid", int'(rf_valid), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_carry", int'(carry), 0);
    chk("abort_wdata", int'(rf_write_data), 0);
    ref_result = 0;
    ref_carry  = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_write", wr_cnt, wr_before);
    chk("abort_r6_kept", int'(rf_mem[6]), 'h33);
    chk("abort_ready_back", int'(instr_ready), 1);
    $display("abort: r6=%02h writes_during=%0d", rf_mem[6], wr_cnt - wr_before);

    // Back-to-back ADDI r1 <- r1 + 1 with instr_valid held high
    run_instr(OP_ADDI, 5'd1, 5'd0, 5'd1, 8'h01, 1'b1);
    run_instr(OP_ADDI, 5'd1, 5'd0, 5'd1, 8'h01, 1'b1);
    run_instr(OP_ADDI, 5'd1, 5'd0, 5'd1, 8'h01, 1'b0);
    chk("b2b_r1_final", int'(rf_mem[1]), 3);

    // Random instructions against the reference model
    for (int k = 0; k < 40; k++) begin
      run_instr(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                8'($urandom_range(0, 255)), (k != 39) && ($urandom_range(0, 1) == 1));
    end

    for (int i = 0; i < 32; i++) chk("rf_final", int'(rf_mem[i]), int'(ref_rf[i]));
    chk("done_pulses", done_cnt, n_instr);
    chk("write_count", wr_cnt, n_writes);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule
